uv_residual_sse: RTL and testbench
==================================

# uv_residual_sse

Downstream consumer of the chroma TrueMotion predictor. Takes one packed 8x8 U plus 8x8 V predicted block and the matching source block. Streams the signed residual (source − prediction) out one row per handshake to the transform stage. Accumulates the sum of squared error (SSE) for the chroma mode decision.

## Interface
Parameters:
- BIT_WIDTH, 8, sample width
- BLOCK_SIZE, 8, samples per row / rows per plane
- UV_SIZE, 16, total rows (8 U rows then 8 V rows)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  pred/src block offered
- in_ready  out  1  block accepted when in_valid && in_ready
- pred  in  BIT_WIDTH*BLOCK_SIZE*UV_SIZE (1024)  predicted block; sample (r,i) at bits [(r*8+i)*8 +: 8]; rows 0–7 U, 8–15 V
- src  in  1024  source block, same packing
- res_valid  out  1  residual row available
- res_ready  in  1  downstream accepts row
- res_data  out  BLOCK_SIZE*(BIT_WIDTH+1) (72)  residual row; sample i at [i*9 +: 9], two's complement
- res_row  out  4  row index 0–15 of res_data
- res_last  out  1  high with row 15
- sse_valid  out  1  one-cycle pulse, sse valid
- sse  out  23  block SSE, held until next block completes

## Operation
- FSM states:
  - IDLE: in_ready=1. On accept, register pred and src, clear row counter and accumulator, go to RUN.
  - RUN: res_valid=1.
    - res_data[i] = src(row,i) − pred(row,i), computed with 9-bit sign extension; range −255..+255.
    - On res_valid && res_ready: add the row's sum of squares (≤520200, 19 bits) to the accumulator and increment row.
    - When row 15 is accepted, go to DONE.
  - DONE: lasts one cycle. Drive sse_valid=1 with the sse register loaded from the final accumulator, then return to IDLE.
- Width rules:
  - Square: 16 bits unsigned.
  - Row sum: 19 bits.
  - Accumulator: 23 bits; maximum 128*65025 = 8,323,200, no overflow.
- in_ready=0 in RUN and DONE. in_valid is ignored there; upstream must hold its data.
- res_data, res_row and res_last stay stable while res_valid && !res_ready.
- Reset values: in_ready=1, res_valid=0, res_last=0, res_row=0, res_data=0, sse_valid=0, sse=0, state IDLE.
- Reset asserted mid-block: the block is abandoned, no sse_valid is produced, and the outputs take their reset values on the next edge.

## Timing
- Accept at edge t → row 0 presented (res_valid=1) after edge t, i.e. visible in cycle t+1.
- With res_ready held 1, one row per cycle: row 15 is accepted at edge t+16, sse_valid is high in cycle t+17, and in_ready is 1 again in cycle t+18.
- Minimum block period: 18 cycles.
- Backpressure adds exactly one cycle per cycle with res_ready=0.
- res_data is combinational from the registered blocks and the row counter. No combinational path from res_ready to res_valid or res_data.
- sse updates only in DONE and holds otherwise.

## Structure
- Shared package uv_pred_pkg contains:
  - BIT_WIDTH, BLOCK_SIZE, UV_SIZE
  - RES_W=9, ROWSUM_W=19, SSE_W=23
  - FSM state enum (IDLE, RUN, DONE)
- The package is reused by the chroma predictor and the transform stage.
- One sub-module: uv_row_sq_sum. It is purely combinational: eight 9-bit residuals in, 19-bit sum of squares out.
- Top level holds the FSM, the row counter, the block registers and the accumulator.

## Test plan
- **Equal blocks:** pred=src=all 0x80, res_ready=1 → 16 rows of res_data=0; rows 0..15 in order; res_last only on row 15; sse=0 pulsed at t+17.
- **Maximum positive:** src=all 0xFF, pred=all 0x00 → every sample 9'h0FF; sse=8,323,200.
- **Maximum negative / plane order:** src=0x00, pred=0xFF in U rows; src=pred in V rows → U rows 9'h101 (−255); V rows 0; sse=4,161,600.
- **Backpressure:** random res_ready (≈50%) with src(r,i)=r*8+i and pred=0 → each row held stable while stalled; exactly 16 handshakes; sse equals the sum of (r*8+i)² = 690,880; in_valid pulses during RUN are ignored.
- **Reset mid-block:** rst asserted for one cycle after row 5 is accepted → next cycle IDLE, in_ready=1, res_valid=0, sse=0, no sse_valid. A following block with src=0x01, pred=0x00 completes normally with sse=128.

Source files
------------

// File: rtl/uv_pred_pkg.sv
// Shared constants and FSM state type for the chroma predictor, residual/SSE
// and transform stages.
package uv_pred_pkg;

  localparam int BIT_WIDTH  = 8;
  localparam int BLOCK_SIZE = 8;
  localparam int UV_SIZE    = 16;

  localparam int RES_W    = 9;
  localparam int ROWSUM_W = 19;
  localparam int SSE_W    = 23;

  localparam int ROW_BITS  = BIT_WIDTH * BLOCK_SIZE;
  localparam int BLOCK_W   = ROW_BITS * UV_SIZE;
  localparam int RES_ROW_W = BLOCK_SIZE * RES_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/uv_row_sq_sum.sv
// Sum of squares of one row of eight signed 9-bit residuals (combinational).
module uv_row_sq_sum
  import uv_pred_pkg::*;
(
  input  logic [RES_ROW_W-1:0] res,
  output logic [ROWSUM_W-1:0]  row_sum
);

  logic [RES_W-1:0] sample;
  logic [RES_W-1:0] mag;
  logic [15:0]      sq;

  // Residuals never reach -256, so the magnitude always fits in 8 bits.
  always_comb begin
    row_sum = '0;
    sample  = '0;
    mag     = '0;
    sq      = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      sample  = res[i*RES_W +: RES_W];
      mag     = sample[RES_W-1] ? (~sample + 9'd1) : sample;
      sq      = mag[7:0] * mag[7:0];
      row_sum = row_sum + {3'b000, sq};
    end
  end

endmodule

// File: rtl/uv_residual_sse.sv
// Streams the chroma residual (src - pred) one row per handshake and
// accumulates the block sum of squared error.
module uv_residual_sse
  import uv_pred_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BLOCK_W-1:0]   pred,
  input  logic [BLOCK_W-1:0]   src,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RES_ROW_W-1:0] res_data,
  output logic [3:0]           res_row,
  output logic                 res_last,
  output logic                 sse_valid,
  output logic [SSE_W-1:0]     sse
);

  state_t               state;
  logic [BLOCK_W-1:0]   pred_q;
  logic [BLOCK_W-1:0]   src_q;
  logic [3:0]           row_q;
  logic [SSE_W-1:0]     acc_q;
  logic [ROW_BITS-1:0]  pred_row;
  logic [ROW_BITS-1:0]  src_row;
  logic [ROWSUM_W-1:0]  row_sum;
  logic [SSE_W-1:0]     acc_next;

  // Row data depends only on registers, never on res_ready.
  assign pred_row = pred_q[{row_q, 6'd0} +: ROW_BITS];
  assign src_row  = src_q[{row_q, 6'd0} +: ROW_BITS];

  always_comb begin
    res_data = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      res_data[i*RES_W +: RES_W] = {1'b0, src_row[i*BIT_WIDTH +: BIT_WIDTH]}
                                 - {1'b0, pred_row[i*BIT_WIDTH +: BIT_WIDTH]};
    end
  end

  uv_row_sq_sum u_row_sq_sum (
    .res     (res_data),
    .row_sum (row_sum)
  );

  assign acc_next = acc_q + {{(SSE_W-ROWSUM_W){1'b0}}, row_sum};
  assign res_row  = row_q;
  assign res_last = res_valid && (row_q == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      sse_valid <= 1'b0;
      sse       <= '0;
      row_q     <= '0;
      acc_q     <= '0;
      pred_q    <= '0;
      src_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          sse_valid <= 1'b0;
          if (in_valid) begin
            pred_q    <= pred;
            src_q     <= src;
            row_q     <= '0;
            acc_q     <= '0;
            in_ready  <= 1'b0;
            res_valid <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (res_ready) begin
            acc_q <= acc_next;
            row_q <= row_q + 4'd1;
            // The final row's sum goes straight into sse so it is valid in DONE.
            if (row_q == 4'd15) begin
              res_valid <= 1'b0;
              sse       <= acc_next;
              sse_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          sse_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          res_valid <= 1'b0;
          sse_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uv_residual_sse.sv
// Directed bench for uv_residual_sse: table-driven uniform blocks plus
// backpressure and mid-block reset sequences.
module tb_uv_residual_sse;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [1023:0]  pred;
  logic [1023:0]  src;
  logic           res_valid;
  logic           res_ready;
  logic [71:0]    res_data;
  logic [3:0]     res_row;
  logic           res_last;
  logic           sse_valid;
  logic [22:0]    sse;

  int total  = 0;
  int passed = 0;

  typedef struct {
    string       name;
    logic [7:0]  pred_u;
    logic [7:0]  pred_v;
    logic [7:0]  src_u;
    logic [7:0]  src_v;
    logic [8:0]  res_u;
    logic [8:0]  res_v;
    logic [22:0] exp_sse;
  } vector_t;

  vector_t vecs[5];

  uv_residual_sse dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pred      (pred),
    .src       (src),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_row   (res_row),
    .res_last  (res_last),
    .sse_valid (sse_valid),
    .sse       (sse)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [1023:0] fill_block(input logic [7:0] u, input logic [7:0] v);
    logic [1023:0] b;
    for (int k = 0; k < 128; k++) b[k*8 +: 8] = (k < 64) ? u : v;
    return b;
  endfunction

  // One full block with res_ready held high, checking every row and the timing.
  task automatic apply_stimulus(input vector_t v);
    logic [8:0] r9;
    @(negedge clk);
    check_output({v.name, " in_ready before accept"}, 72'(in_ready), 72'(1));
    pred      = fill_block(v.pred_u, v.pred_v);
    src       = fill_block(v.src_u, v.src_v);
    in_valid  = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int r = 0; r < 16; r++) begin
      r9 = (r < 8) ? v.res_u : v.res_v;
      check_output($sformatf("%s row %0d ctrl {valid,last,row}", v.name, r),
                   72'({res_valid, res_last, res_row}), 72'({1'b1, (r == 15), 4'(r)}));
      check_output($sformatf("%s row %0d data", v.name, r), res_data, {8{r9}});
      @(negedge clk);
    end
    check_output({v.name, " sse_valid at t+17"}, 72'({sse_valid, res_valid, in_ready}), 72'({1'b1, 1'b0, 1'b0}));
    check_output({v.name, " sse"}, 72'(sse), 72'(v.exp_sse));
    @(negedge clk);
    check_output({v.name, " in_ready at t+18"}, 72'({in_ready, sse_valid}), 72'({1'b1, 1'b0}));
    check_output({v.name, " sse held"}, 72'(sse), 72'(v.exp_sse));
  endtask

  initial begin
    logic [71:0] exp_row;
    logic [71:0] saved_data;
    logic [3:0]  saved_row;
    logic        prev_stall;
    logic        done;
    int          hs;
    int          pulses;

    vecs[0] = '{"equal",   8'h80, 8'h80, 8'h80, 8'h80, 9'h000, 9'h000, 23'd0};
    vecs[1] = '{"maxpos",  8'h00, 8'h00, 8'hFF, 8'hFF, 9'h0FF, 9'h0FF, 23'd8323200};
    vecs[2] = '{"maxneg",  8'hFF, 8'h40, 8'h00, 8'h40, 9'h101, 9'h000, 23'd4161600};
    vecs[3] = '{"mixed",   8'h20, 8'h10, 8'h10, 8'h30, 9'h1F0, 9'h020, 23'd81920};
    vecs[4] = '{"ones",    8'h00, 8'h00, 8'h01, 8'h01, 9'h001, 9'h001, 23'd128};

    rst       = 1'b1;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    pred      = '0;
    src       = '0;
    repeat (2) @(negedge clk);
    check_output("reset ctrl {in_ready,res_valid,res_last,sse_valid}",
                 72'({in_ready, res_valid, res_last, sse_valid}), 72'({1'b1, 1'b0, 1'b0, 1'b0}));
    check_output("reset res_row", 72'(res_row), 72'(0));
    check_output("reset res_data", res_data, 72'(0));
    check_output("reset sse", 72'(sse), 72'(0));
    rst = 1'b0;

    for (int n = 0; n < 4; n++) apply_stimulus(vecs[n]);

    // Backpressure: src(r,i)=r*8+i, pred=0, random res_ready and stray in_valid.
    $display("[TB] backpressure sequence");
    pred = '0;
    for (int k = 0; k < 128; k++) src[k*8 +: 8] = 8'(k);
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
    src        = {128{8'hAA}};
    pred       = {128{8'h55}};
    hs         = 0;
    prev_stall = 1'b0;
    done       = 1'b0;
    saved_data = '0;
    saved_row  = '0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (prev_stall)
        check_output($sformatf("bp stall hold row %0d", saved_row),
                     {res_data[67:0], res_row}, {saved_data[67:0], saved_row});
      if (sse_valid) begin
        done     = 1'b1;
        in_valid = 1'b0;
      end else if (res_valid) begin
        for (int i = 0; i < 8; i++) exp_row[i*9 +: 9] = 9'((hs % 16) * 8 + i);
        check_output($sformatf("bp row %0d data", hs), {res_data[67:0], res_row}, {exp_row[67:0], 4'(hs)});
        res_ready  = 1'($urandom_range(0, 1));
        in_valid   = 1'($urandom_range(0, 1));
        if (res_ready) hs++;
        prev_stall = !res_ready;
        saved_data = res_data;
        saved_row  = res_row;
      end else begin
        prev_stall = 1'b0;
      end
      if (!done) @(negedge clk);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    check_output("bp completed within budget", 72'(done), 72'(1));
    check_output("bp handshake count", 72'(hs), 72'(16));
    check_output("bp sse", 72'(sse), 72'(690880));
    @(negedge clk);
    check_output("bp back to idle", 72'({in_ready, res_valid}), 72'({1'b1, 1'b0}));

    // Reset one cycle after row 5 is accepted.
    $display("[TB] mid-block reset sequence");
    pred = fill_block(8'h00, 8'h00);
    src  = fill_block(8'h02, 8'h02);
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check_output("rst pre row", 72'({res_valid, res_row}), 72'({1'b1, 4'd6}));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("rst ctrl {in_ready,res_valid,res_last,sse_valid}",
                 72'({in_ready, res_valid, res_last, sse_valid}), 72'({1'b1, 1'b0, 1'b0, 1'b0}));
    check_output("rst sse cleared", 72'(sse), 72'(0));
    check_output("rst res_row/res_data", {res_data[67:0], res_row}, 72'(0));
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sse_valid) pulses++;
    end
    check_output("rst no sse_valid afterwards", 72'(pulses), 72'(0));

    apply_stimulus(vecs[4]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
